// File: rtl/icap_pkg.sv
// icap_pkg: shared types and helpers for the ICAPE2 controller.
// Holds the controller state encoding, parameter legality checks and the
// per-byte bit reversal that the ICAP data buses require.
package icap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    TURN_RD = 3'd2,
    RD      = 3'd3,
    DRAIN   = 3'd4,
    TURN_WR = 3'd5
  } icap_state_e;

  // ICAPE2 only supports 8, 16 and 32 bit buses.
  function automatic logic icap_width_ok(input int width);
    return (width == 8) || (width == 16) || (width == 32);
  endfunction

  // FIFO depth must be a power of two between 4 and 1024.
  function automatic logic fifo_depth_ok(input int depth);
    return (depth >= 4) && (depth <= 1024) && ((depth & (depth - 1)) == 0);
  endfunction

  // ICAP carries each byte bit-reversed in place: x[7:0] -> y[0:7] etc.
  function automatic logic [31:0] byte_bitrev(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        y[8*b + k] = x[8*b + 7 - k];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/icap_prim.sv
// icap_prim: wrapper around the ICAPE2 configuration primitive.
// With ICAP_PRIM_UNISIM defined the real Xilinx ICAPE2 is instantiated.
// Otherwise a behavioural stand-in is built: each read cycle (csib=0,
// rdwrb=1) returns, RD_LAT clocks later on o, the word
// 0x01020304 + n*0x04040404 (n = read index since csib was last high),
// presented in ICAP byte-bit-reversed order. Write words are absorbed.
module icap_prim import icap_pkg::*; #(
  parameter int ICAP_WIDTH = 32,
  parameter int RD_LAT     = 3
) (
  input  logic                  c,
  input  logic                  csib,
  input  logic                  rdwrb,
  input  logic [ICAP_WIDTH-1:0] i,
  output logic [ICAP_WIDTH-1:0] o
);

`ifdef ICAP_PRIM_UNISIM

  localparam string WIDTH_ATTR = (ICAP_WIDTH == 8)  ? "X8"  :
                                 (ICAP_WIDTH == 16) ? "X16" : "X32";

  logic [31:0] i_full_s;
  logic [31:0] o_full_s;

  // Zero-extend the narrow write bus onto the 32-bit primitive port.
  always_comb begin
    i_full_s                 = 32'd0;
    i_full_s[ICAP_WIDTH-1:0] = i;
  end

  ICAPE2 #(
    .ICAP_WIDTH (WIDTH_ATTR)
  ) u_icape2 (
    .CLK   (c),
    .CSIB  (csib),
    .RDWRB (rdwrb),
    .I     (i_full_s),
    .O     (o_full_s)
  );

  assign o = o_full_s[ICAP_WIDTH-1:0];

`else

  logic [15:0]           k_r;
  logic [31:0]           pat_s;
  logic [31:0]           pat_rev_s;
  logic                  rd_s;
  logic [ICAP_WIDTH-1:0] d_r [RD_LAT];
  logic                  unused_s;

  assign rd_s      = !csib && rdwrb;
  assign pat_s     = 32'h0102_0304 + (32'h0404_0404 * {16'd0, k_r});
  assign pat_rev_s = byte_bitrev(pat_s);
  assign unused_s  = ^i;

  // Read index: restarts whenever the port is deselected.
  always_ff @(posedge c) begin
    if (csib) begin
      k_r <= 16'd0;
    end else if (rdwrb) begin
      k_r <= k_r + 16'd1;
    end else begin
      k_r <= k_r;
    end
  end

  // Read latency pipeline feeding o.
  always_ff @(posedge c) begin
    d_r[0] <= rd_s ? pat_rev_s[ICAP_WIDTH-1:0] : {ICAP_WIDTH{1'b0}};
    for (int k = 1; k < RD_LAT; k++) begin
      d_r[k] <= d_r[k-1];
    end
  end

  assign o = d_r[RD_LAT-1];

`endif

endmodule

// File: rtl/icap_ctl.sv
// icap_ctl: buffered controller for the 7-series ICAPE2 port.
// Configuration words are queued in a first-word-fall-through FIFO and
// streamed into ICAP at one word per clock; readback bursts are run on
// request and the returned words handed back with rd_valid strobes.
// Optional build macro ICAP_WRCOUNT_EN adds the wr_count output that
// counts words delivered to ICAP.
module icap_ctl import icap_pkg::*; #(
  parameter int ICAP_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_LAT     = 3
) (
  input  logic        c,
  input  logic        r,
  input  logic        w,
  input  logic [31:0] i,
  output logic        full,
  output logic        ovf,
  input  logic        rd_req,
  input  logic [15:0] rd_len,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done
`ifdef ICAP_WRCOUNT_EN
  ,
  output logic [31:0] wr_count
`endif
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT    = (AW+1)'(1);
  localparam logic [15:0] DRAIN_LOAD = 16'(RD_LAT - 1);

  if (!icap_width_ok(ICAP_WIDTH) || !fifo_depth_ok(FIFO_DEPTH) || (RD_LAT < 1)) begin : g_bad_param
    $error("icap_ctl: illegal ICAP_WIDTH, FIFO_DEPTH or RD_LAT");
  end

  // FIFO storage and bookkeeping
  logic [31:0]           mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [31:0]           head_s;
  logic [31:0]           head_rev_s;

  // Sequencer
  icap_state_e           state_r;
  icap_state_e           state_s;
  logic [15:0]           cnt_r;
  logic                  rdwrb_r;
  logic                  csib_s;
  logic                  rd_accept_s;
  logic                  rd_cycle_s;

  // ICAP data and readback capture
  logic [ICAP_WIDTH-1:0] icap_i_s;
  logic [ICAP_WIDTH-1:0] icap_o_s;
  logic [31:0]           o_ext_s;
  logic [RD_LAT-1:0]     rd_pipe_r;
  logic [31:0]           rd_data_r;
  logic                  rd_valid_r;
  logic                  ovf_r;
  logic                  done_r;

  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign push_s      = w && !full_s;
  assign pop_s       = (state_r == WR) && !empty_s;
  assign head_s      = mem_r[rd_ptr_r];
  assign head_rev_s  = byte_bitrev(head_s);
  assign rd_accept_s = (state_r == IDLE) && empty_s && rd_req;
  assign rd_cycle_s  = (state_r == RD);

  // FIFO storage write; contents need no reset since count_r gates reads.
  always_ff @(posedge c) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge c) begin
    if (r) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: a write strobe while full is lost, even if a pop frees a slot.
  always_ff @(posedge c) begin
    if (r) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r || (w && full_s);
    end
  end

  // Next-state logic; WR leaves as the last queued word is sent.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_s = WR;
        end else if (rd_req) begin
          state_s = TURN_RD;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        if (empty_s) begin
          state_s = IDLE;
        end else if ((count_r == ONE_CNT) && !push_s) begin
          state_s = IDLE;
        end else begin
          state_s = WR;
        end
      end
      TURN_RD: begin
        if (cnt_r == 16'd0) begin
          state_s = DRAIN;
        end else begin
          state_s = RD;
        end
      end
      RD: begin
        if (cnt_r == 16'd1) begin
          state_s = DRAIN;
        end else begin
          state_s = RD;
        end
      end
      DRAIN: begin
        if (cnt_r == 16'd0) begin
          state_s = TURN_WR;
        end else begin
          state_s = DRAIN;
        end
      end
      TURN_WR: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge c) begin
    if (r) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shared down-counter: read length in RD, then the drain wait in DRAIN.
  always_ff @(posedge c) begin
    if (r) begin
      cnt_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE:    cnt_r <= rd_accept_s ? rd_len : cnt_r;
        TURN_RD: cnt_r <= (cnt_r == 16'd0) ? DRAIN_LOAD : cnt_r;
        RD:      cnt_r <= (cnt_r == 16'd1) ? DRAIN_LOAD : (cnt_r - 16'd1);
        DRAIN:   cnt_r <= (cnt_r == 16'd0) ? cnt_r : (cnt_r - 16'd1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // RDWRB only moves in the turnaround states, where CSIB is high.
  always_ff @(posedge c) begin
    if (r) begin
      rdwrb_r <= 1'b0;
    end else begin
      case (state_r)
        TURN_RD: rdwrb_r <= 1'b1;
        TURN_WR: rdwrb_r <= 1'b0;
        default: rdwrb_r <= rdwrb_r;
      endcase
    end
  end

  // Chip select and write data driven from the current state and FIFO head.
  always_comb begin
    csib_s   = 1'b1;
    icap_i_s = {ICAP_WIDTH{1'b0}};
    case (state_r)
      WR: begin
        if (!empty_s) begin
          csib_s   = 1'b0;
          icap_i_s = head_rev_s[ICAP_WIDTH-1:0];
        end else begin
          csib_s   = 1'b1;
        end
      end
      RD:      csib_s = 1'b0;
      default: csib_s = 1'b1;
    endcase
  end

  // Zero-extend the primitive read bus to a full word.
  always_comb begin
    o_ext_s                 = 32'd0;
    o_ext_s[ICAP_WIDTH-1:0] = icap_o_s;
  end

  // Read delay line: a tap arrival marks valid data on O, registered into rd_data.
  always_ff @(posedge c) begin
    if (r) begin
      rd_pipe_r  <= {RD_LAT{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else begin
      rd_pipe_r[0] <= rd_cycle_s;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe_r[k] <= rd_pipe_r[k-1];
      end
      rd_valid_r <= rd_pipe_r[RD_LAT-1];
      if (rd_pipe_r[RD_LAT-1]) begin
        rd_data_r <= byte_bitrev(o_ext_s);
      end
    end
  end

  // Completion pulse on the first cycle back in IDLE after a readback.
  always_ff @(posedge c) begin
    if (r) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == TURN_WR);
    end
  end

`ifdef ICAP_WRCOUNT_EN
  logic [31:0] wr_count_r;

  // Words delivered to ICAP; wraps naturally.
  always_ff @(posedge c) begin
    if (r) begin
      wr_count_r <= 32'd0;
    end else if (pop_s) begin
      wr_count_r <= wr_count_r + 32'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign wr_count = wr_count_r;
`endif

  icap_prim #(
    .ICAP_WIDTH (ICAP_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_prim (
    .c     (c),
    .csib  (csib_s),
    .rdwrb (rdwrb_r),
    .i     (icap_i_s),
    .o     (icap_o_s)
  );

  assign full     = full_s;
  assign ovf      = ovf_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = (state_r != IDLE);
  assign done     = done_r;

endmodule

// File: doc/icap_ctl.md
Name: icap_ctl

Overview:
- Parametrised, buffered controller for the Xilinx 7-series ICAPE2 configuration port.
- Accepts configuration words from fabric logic into a FIFO and streams them into ICAP at one word per clock.
- Performs readback bursts on request and returns the read words to fabric.
- Sits between the partial-reconfiguration/scrubbing logic and the primitive. The primitive lives in sub-module icap_prim, so a bench can substitute a behavioural model.

Parameters:
- ICAP_WIDTH, 32, ICAP bus width in bits, legal values 8/16/32. The primitive attribute is "X8"/"X16"/"X32". Narrower widths use i[W-1:0] and rd_data[W-1:0]; upper bits are zero.
- FIFO_DEPTH, 16, write FIFO depth in words, a power of 2 from 4 to 1024.
- RD_LAT, 3, clocks from CSIB/RDWRB read cycle to valid data on O.

Ports:
- c  in  1  clock; also drives ICAP CLK directly (no derived clocks)
- r  in  1  synchronous active-high reset
- w  in  1  write strobe; word i accepted when w && !full
- i  in  32  configuration word, normal bit order
- full  out  1  FIFO full
- ovf  out  1  sticky; set when w && full; cleared only by r
- rd_req  in  1  readback request pulse; ignored unless state is IDLE and the FIFO is empty
- rd_len  in  16  number of words to read; sampled on an accepted rd_req; 0 means no ICAP read cycles
- rd_data  out  32  readback word, normal bit order
- rd_valid  out  1  one-cycle strobe per readback word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a readback completes and the port is back in write mode

Behaviour:
- Reset values: full=0, ovf=0, rd_data=0, rd_valid=0, busy=0, done=0. FIFO is emptied and the state is IDLE. ICAP CSIB=1, RDWRB=0.
- Reset mid-operation drops any in-flight write or read and deasserts CSIB on the next edge. Words still in the FIFO are lost.
- Bit order: the ICAP I bus carries each byte of the word bit-reversed in place (i[7:0] -> I[0:7] etc.). O is un-reversed the same way before it reaches rd_data.
- FIFO: first-word-fall-through, registered full.
  - Simultaneous push and pop when full: the push is rejected and ovf is set, even though a slot frees this cycle.
  - full is recomputed combinationally from the registered count and is not lookahead.
- States:
  - IDLE: CSIB=1. FIFO nonempty -> WR. Accepted rd_req (FIFO empty) -> TURN_RD.
  - WR: per cycle with FIFO nonempty, CSIB=0, RDWRB=0, I=head word, pop. FIFO empty -> IDLE, with CSIB=1 on that cycle.
  - TURN_RD: one cycle with CSIB=1, RDWRB<=1. Then RD, or DRAIN if rd_len=0.
  - RD: CSIB=0, RDWRB=1 for exactly rd_len cycles (16-bit down-counter), then -> DRAIN.
  - DRAIN: CSIB=1. Wait RD_LAT cycles so all data is captured, then -> TURN_WR.
  - TURN_WR: one cycle with CSIB=1, RDWRB<=0, then -> IDLE and pulse done.
- RDWRB never changes while CSIB=0.
- Read capture: a delay line of length RD_LAT tracks read cycles. Each tap arrival registers O into rd_data with rd_valid=1, so rd_data lags O by one extra clock. Exactly rd_len rd_valid pulses per request.
- Writes accepted during a readback are buffered in the FIFO and sent after TURN_WR.
- Latency: word written at cycle n with FIFO empty and state IDLE reaches ICAP I with CSIB=0 at cycle n+2.

Optional Feature:
- ICAP_WRCOUNT_EN.
- Defined: adds output wr_count [31:0], the count of words delivered to ICAP (CSIB=0, RDWRB=0 cycles). Wraps at 2^32. Reset to 0. Lets the scrubber verify frame counts.
- Undefined: port and counter absent; no other change.

Decomposition:
- Package icap_pkg: state enum (IDLE, WR, TURN_RD, RD, DRAIN, TURN_WR), width-legality function, byte-bit-reverse function.
- Sub-module icap_prim: wraps ICAPE2 with ICAP_WIDTH; ports c, csib, rdwrb, i, o.
- FIFO is inline; no separate module.

Test Plan:
- Reset, then write 0x12345678 once -> at cycle n+2, CSIB=0, RDWRB=0, I=0x482C6A1E; next cycle CSIB=1; busy high for 1 cycle.
- FIFO_DEPTH=16: hold w for 20 cycles with the ICAP model blocked (forced readback in progress) -> full after 16 words; ovf=1; 16 words later reach ICAP in order.
- rd_req with rd_len=4, model O returns 0x0102_0304.. -> CSIB high exactly 1 cycle before RDWRB rises; 4 RD cycles; 4 rd_valid pulses with correct un-reversed data; done pulse; RDWRB back to 0.
- rd_req with rd_len=0 -> no CSIB=0 cycles, no rd_valid, done pulse after TURN_RD, DRAIN (RD_LAT) and TURN_WR.
- Writes during RD -> buffered, no ICAP writes until after done; then sent in order.
- Assert r during RD (rd_len=100) -> next edge CSIB=1, RDWRB=0, busy=0, no further rd_valid; with ICAP_WRCOUNT_EN, wr_count=0.
